// File: rtl/fifo_pkg.sv
// Shared constants for the synchronous fifo family and its pop-side reader.
// Holds the credit rule used to decide when another pop may be issued.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH_DEF  = 8;
    localparam int unsigned FIFO_RD_LATENCY = 1;
    localparam int unsigned SKID_DEPTH      = 2;

    typedef logic [1:0] occ_t;

    // Words already owed to the skid buffer after this cycle's pop must leave room for one more.
    function automatic logic credit_ok(input occ_t occ, input logic inflight, input logic pop);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return pending < 3'(SKID_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer: captures words returned by the fifo and presents the oldest one.
// Writes and pops may coincide; occupancy then stays unchanged.
module fifo_reader_skid
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  pop,
    output occ_t                  occ,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
    logic                  wr_ptr;
    logic                  rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + occ_t'(wr_en) - occ_t'(pop);
        end
    end

    assign out_valid = (occ != '0);
    assign out_data  = mem[rd_ptr];

endmodule

// File: rtl/fifo_reader.sv
// Pop-side controller for the synchronous fifo: issues deq, absorbs the registered read
// latency and streams entries as valid/ready. Define FIFO_READER_COUNT_EN to enable pop_count.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_deq,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [15:0]           pop_count
);

    logic [FIFO_RD_LATENCY-1:0] inflight;
    occ_t                       occ;
    logic                       pop;

    assign pop = out_valid & out_ready;

    // Gated by reset so no pop is requested while the reader is held in reset.
    assign fifo_deq = reset & rd_en & ~fifo_empty & credit_ok(occ, inflight, pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            inflight <= fifo_deq;
        end
    end

    fifo_reader_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (inflight),
        .wr_data  (fifo_data),
        .pop      (pop),
        .occ      (occ),
        .out_valid(out_valid),
        .out_data (out_data)
    );

`ifdef FIFO_READER_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pop_count <= '0;
        end else if (pop) begin
            pop_count <= pop_count + 16'd1;
        end
    end
`else
    assign pop_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader: a behavioural fifo feeds the DUT, and a queue-based model of the
// reader is checked against the DUT outputs mid-cycle on every cycle.
module tb_fifo_reader;

    logic       clk;
    logic       reset;
    logic       rd_en;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_deq;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [15:0] pop_count;

    fifo_reader #(
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .fifo_deq  (fifo_deq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pop_count (pop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural fifo: storage written by the stimulus, read pointer advanced on DUT deq.
    logic [7:0] mem [1024];
    int         wr_idx = 0;
    int         f_rd   = 0;

    assign fifo_empty = (wr_idx == f_rd);

    always @(posedge clk) begin
        if (fifo_deq) begin
            fifo_data <= mem[f_rd];
            f_rd      <= f_rd + 1;
        end
    end

    // Reader model: words owned by the reader in arrival order, plus the one in flight.
    logic [7:0] mq[$];
    int         m_rd     = 0;
    int         m_infl   = 0;
    logic [7:0] m_word   = '0;
    int         m_count  = 0;

    int n_tests = 0;
    int n_fail  = 0;

    logic       s_valid, s_deq, s_hs, s_empty;
    logic [7:0] s_data;
    logic [15:0] s_count;

`ifdef FIFO_READER_COUNT_EN
    localparam bit COUNT_EN = 1'b1;
`else
    localparam bit COUNT_EN = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] w);
        mem[wr_idx] = w;
        wr_idx      = wr_idx + 1;
    endtask

    // One clock cycle: sample and check mid-cycle, advance model, return just after next edge.
    task automatic step();
        bit exp_valid, exp_pop, exp_deq;
        int expc;
        @(negedge clk);
        s_valid = out_valid;
        s_data  = out_data;
        s_deq   = fifo_deq;
        s_hs    = out_valid & out_ready;
        s_empty = fifo_empty;
        s_count = pop_count;
        if (!reset) begin
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_deq", 32'(fifo_deq), 32'd0);
            check("rst_count", 32'(pop_count), 32'd0);
            mq.delete();
            m_infl  = 0;
            m_count = 0;
        end else begin
            exp_valid = (mq.size() != 0);
            exp_pop   = exp_valid && out_ready;
            exp_deq   = rd_en && (wr_idx > m_rd) &&
                        (mq.size() + m_infl - int'(exp_pop) < 2);
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            if (exp_valid) check("out_data", 32'(out_data), 32'(mq[0]));
            check("fifo_deq", 32'(fifo_deq), 32'(exp_deq));
            expc = COUNT_EN ? (m_count & 16'hFFFF) : 0;
            check("pop_count", 32'(pop_count), 32'(expc));
            if (exp_pop) begin
                void'(mq.pop_front());
                m_count++;
            end
            if (m_infl != 0) mq.push_back(m_word);
            m_infl = exp_deq ? 1 : 0;
            if (exp_deq) begin
                m_word = mem[m_rd];
                m_rd++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         first_deq, first_valid, last_hs, nhs, ndeq, cyc, npush;
        logic [7:0] got [64];

        reset     = 1'b0;
        rd_en     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) step();
        check("init_valid", 32'(s_valid), 32'd0);
        check("init_data", 32'(s_data), 32'd0);
        check("init_deq", 32'(s_deq), 32'd0);
        check("init_count", 32'(s_count), 32'd0);
        reset = 1'b1;
        step();

        // Stream 0..15 at full rate
        for (int i = 0; i < 16; i++) push(8'(i));
        rd_en = 1'b1; out_ready = 1'b1;
        first_deq = -1; first_valid = -1; last_hs = -1; nhs = 0;
        for (int c = 0; c < 40 && nhs < 16; c++) begin
            step();
            if (s_deq && first_deq < 0) first_deq = c;
            if (s_valid && first_valid < 0) first_valid = c;
            if (s_hs) begin
                got[nhs] = s_data;
                nhs++;
                last_hs = c;
            end
        end
        check("stream_count", 32'(nhs), 32'd16);
        check("stream_latency", 32'(first_valid - first_deq), 32'd2);
        check("stream_back_to_back", 32'(last_hs - first_valid), 32'd15);
        for (int i = 0; i < 16; i++) check("stream_word", 32'(got[i]), 32'(i));
        step();
        check("stream_idle_valid", 32'(s_valid), 32'd0);
        check("stream_idle_empty", 32'(s_empty), 32'd1);
        check("stream_idle_deq", 32'(s_deq), 32'd0);
        check("stream_pop_count", 32'(s_count), COUNT_EN ? 32'd16 : 32'd0);

        // Backpressure: only two words may be pulled while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
        ndeq = 0;
        repeat (10) begin
            step();
            if (s_deq) ndeq++;
        end
        check("bp_deqs", 32'(ndeq), 32'd2);
        check("bp_valid", 32'(s_valid), 32'd1);
        check("bp_head", 32'(s_data), 32'hA0);
        out_ready = 1'b1;
        nhs = 0;
        for (int c = 0; c < 40 && nhs < 16; c++) begin
            step();
            if (s_hs) begin
                got[nhs] = s_data;
                nhs++;
            end
        end
        check("bp_count", 32'(nhs), 32'd16);
        for (int i = 0; i < 16; i++) check("bp_word", 32'(got[i]), 32'hA0 + 32'(i));

        // Random ready with trickle refill
        npush = 0; nhs = 0;
        for (int c = 0; c < 200; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ((wr_idx - f_rd) < 16 && $urandom_range(0, 3) != 0) begin
                push(8'($urandom_range(0, 255)));
                npush++;
            end
            step();
            if (s_hs) nhs++;
        end
        out_ready = 1'b1;
        repeat (30) begin
            step();
            if (s_hs) nhs++;
        end
        check("rand_no_loss", 32'(nhs), 32'(npush));
        check("rand_drained", 32'(s_valid), 32'd0);

        // rd_en drop after five pops
        for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
        ndeq = 0; nhs = 0; cyc = 0;
        while (ndeq < 5 && cyc < 20) begin
            step();
            cyc++;
            if (s_deq) ndeq++;
            if (s_hs) nhs++;
        end
        check("rden_deqs", 32'(ndeq), 32'd5);
        rd_en = 1'b0;
        repeat (6) begin
            step();
            if (s_deq) ndeq++;
            if (s_hs) nhs++;
        end
        check("rden_delivered", 32'(nhs), 32'd5);
        check("rden_total_deqs", 32'(ndeq), 32'd5);
        check("rden_idle_valid", 32'(s_valid), 32'd0);

        // Async reset mid-stream with the buffer full
        rd_en = 1'b1; out_ready = 1'b0;
        repeat (4) step();
        check("pre_rst_valid", 32'(s_valid), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_deq", 32'(fifo_deq), 32'd0);
        check("async_rst_count", 32'(pop_count), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        nhs = 0;
        repeat (20) begin
            step();
            if (s_hs) nhs++;
        end
        check("post_rst_delivered", 32'(nhs), 32'd3);
        check("post_rst_empty", 32'(s_empty), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
